// File: rtl/e203_exu_regfile_mp_if.sv
// Bundles the read, write, issue/scoreboard and flush signals of the
// multi-port register file so dispatch and writeback share one port object.
interface e203_exu_regfile_mp_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RFIDX_W  = 5,
  parameter int unsigned RD_PORTS = 4,
  parameter int unsigned WR_PORTS = 2
);
  logic [RD_PORTS*RFIDX_W-1:0] rd_idx;
  logic [RD_PORTS*XLEN-1:0]    rd_dat;
  logic [RD_PORTS-1:0]         rd_pend;
  logic [WR_PORTS-1:0]         wr_en;
  logic [WR_PORTS*RFIDX_W-1:0] wr_idx;
  logic [WR_PORTS*XLEN-1:0]    wr_dat;
  logic                        iss_vld;
  logic [RFIDX_W-1:0]          iss_idx;
  logic                        iss_rdy;
  logic                        flush;
  logic [XLEN-1:0]             x1_r;

  modport master (
    output rd_idx, wr_en, wr_idx, wr_dat, iss_vld, iss_idx, flush,
    input  rd_dat, rd_pend, iss_rdy, x1_r
  );

  modport slave (
    input  rd_idx, wr_en, wr_idx, wr_dat, iss_vld, iss_idx, flush,
    output rd_dat, rd_pend, iss_rdy, x1_r
  );
endinterface

// File: rtl/e203_exu_regfile_mp.sv
// Multi-port GPR file with per-register write-pending scoreboard, fixed
// highest-port-wins write priority and optional write-to-read bypass.
module e203_exu_regfile_mp #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RFREG_NUM = 32,
  parameter int unsigned RFIDX_W   = 5,
  parameter int unsigned RD_PORTS  = 4,
  parameter int unsigned WR_PORTS  = 2,
  parameter int unsigned BYPASS    = 1
) (
  input logic                  clk,
  input logic                  rst,
  e203_exu_regfile_mp_if.slave rf
);
  localparam bit ByPass = (BYPASS != 0);

  logic [XLEN-1:0]      regs_q [1:RFREG_NUM-1];
  logic [XLEN-1:0]      regs_d [1:RFREG_NUM-1];
  logic [RFREG_NUM-1:1] pend_q;
  logic [RFREG_NUM-1:1] pend_d;

  logic [RFREG_NUM-1:1] wr_hit;
  logic [XLEN-1:0]      wr_val [1:RFREG_NUM-1];

  logic [RD_PORTS*XLEN-1:0] rd_dat;
  logic [RD_PORTS-1:0]      rd_pend;
  logic                     iss_rdy;
  logic                     iss_set;

  // Later ports override earlier ones, giving highest-numbered-port priority.
  // Only indices 1..RFREG_NUM-1 have a slot, so x0 and out-of-range writes fall away.
  always_comb begin : wr_resolve
    for (int unsigned r = 1; r < RFREG_NUM; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      for (int unsigned p = 0; p < WR_PORTS; p++) begin
        if (rf.wr_en[p] && (rf.wr_idx[p*RFIDX_W +: RFIDX_W] == RFIDX_W'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = rf.wr_dat[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin : rd_mux
    rd_dat  = '0;
    rd_pend = '0;
    for (int unsigned k = 0; k < RD_PORTS; k++) begin
      for (int unsigned r = 1; r < RFREG_NUM; r++) begin
        if (rf.rd_idx[k*RFIDX_W +: RFIDX_W] == RFIDX_W'(r)) begin
          if (ByPass && wr_hit[r]) begin
            rd_dat[k*XLEN +: XLEN] = wr_val[r];
          end else begin
            rd_dat[k*XLEN +: XLEN] = regs_q[r];
            rd_pend[k]             = pend_q[r];
          end
        end
      end
    end
  end

  // A completing write to the issue target frees it this cycle regardless of bypass.
  always_comb begin : iss_check
    iss_rdy = 1'b1;
    for (int unsigned r = 1; r < RFREG_NUM; r++) begin
      if (rf.iss_idx == RFIDX_W'(r)) begin
        iss_rdy = ~pend_q[r] | wr_hit[r];
      end
    end
    iss_set = rf.iss_vld & iss_rdy & ~rf.flush;
  end

  always_comb begin : next_state
    for (int unsigned r = 1; r < RFREG_NUM; r++) begin
      regs_d[r] = wr_hit[r] ? wr_val[r] : regs_q[r];
      pend_d[r] = pend_q[r];
      if (wr_hit[r]) begin
        pend_d[r] = 1'b0;
      end
      if (rf.flush) begin
        pend_d[r] = 1'b0;
      end else if (iss_set && (rf.iss_idx == RFIDX_W'(r))) begin
        pend_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 1; r < RFREG_NUM; r++) begin
        regs_q[r] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int unsigned r = 1; r < RFREG_NUM; r++) begin
        regs_q[r] <= regs_d[r];
      end
      pend_q <= pend_d;
    end
  end

  assign rf.rd_dat  = rd_dat;
  assign rf.rd_pend = rd_pend;
  assign rf.iss_rdy = iss_rdy;
  assign rf.x1_r    = regs_q[1];
endmodule

// File: tb/tb_e203_exu_regfile_mp.sv
// Drives a 32-entry bypassing instance and a 16-entry non-bypassing instance
// with identical stimulus and compares both against a behavioural model.
module tb_e203_exu_regfile_mp;
  localparam int XLEN = 32;
  localparam int IW   = 5;
  localparam int RDP  = 4;
  localparam int WRP  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  e203_exu_regfile_mp_if #(.XLEN(XLEN), .RFIDX_W(IW), .RD_PORTS(RDP), .WR_PORTS(WRP)) ifa ();
  e203_exu_regfile_mp_if #(.XLEN(XLEN), .RFIDX_W(IW), .RD_PORTS(RDP), .WR_PORTS(WRP)) ifb ();

  e203_exu_regfile_mp #(.XLEN(XLEN), .RFREG_NUM(32), .RFIDX_W(IW), .RD_PORTS(RDP),
                        .WR_PORTS(WRP), .BYPASS(1))
    dut_a (.clk(clk), .rst(rst), .rf(ifa));

  e203_exu_regfile_mp #(.XLEN(XLEN), .RFREG_NUM(16), .RFIDX_W(IW), .RD_PORTS(RDP),
                        .WR_PORTS(WRP), .BYPASS(0))
    dut_b (.clk(clk), .rst(rst), .rf(ifb));

  logic [IW-1:0]   d_rd_idx [RDP];
  logic            d_wr_en  [WRP];
  logic [IW-1:0]   d_wr_idx [WRP];
  logic [XLEN-1:0] d_wr_dat [WRP];
  logic            d_iss_vld;
  logic [IW-1:0]   d_iss_idx;
  logic            d_flush;

  logic [RDP*IW-1:0]   p_rd_idx;
  logic [WRP-1:0]      p_wr_en;
  logic [WRP*IW-1:0]   p_wr_idx;
  logic [WRP*XLEN-1:0] p_wr_dat;

  always_comb begin
    p_rd_idx = '0;
    p_wr_en  = '0;
    p_wr_idx = '0;
    p_wr_dat = '0;
    for (int k = 0; k < RDP; k++) p_rd_idx[k*IW +: IW] = d_rd_idx[k];
    for (int p = 0; p < WRP; p++) begin
      p_wr_en[p]              = d_wr_en[p];
      p_wr_idx[p*IW +: IW]    = d_wr_idx[p];
      p_wr_dat[p*XLEN +: XLEN] = d_wr_dat[p];
    end
  end

  assign ifa.rd_idx = p_rd_idx;  assign ifb.rd_idx = p_rd_idx;
  assign ifa.wr_en  = p_wr_en;   assign ifb.wr_en  = p_wr_en;
  assign ifa.wr_idx = p_wr_idx;  assign ifb.wr_idx = p_wr_idx;
  assign ifa.wr_dat = p_wr_dat;  assign ifb.wr_dat = p_wr_dat;
  assign ifa.iss_vld = d_iss_vld; assign ifb.iss_vld = d_iss_vld;
  assign ifa.iss_idx = d_iss_idx; assign ifb.iss_idx = d_iss_idx;
  assign ifa.flush   = d_flush;   assign ifb.flush   = d_flush;

  logic [RDP*XLEN-1:0] o_dat  [2];
  logic [RDP-1:0]      o_pend [2];
  logic                o_rdy  [2];
  logic [XLEN-1:0]     o_x1   [2];
  assign o_dat[0] = ifa.rd_dat;   assign o_dat[1] = ifb.rd_dat;
  assign o_pend[0] = ifa.rd_pend; assign o_pend[1] = ifb.rd_pend;
  assign o_rdy[0] = ifa.iss_rdy;  assign o_rdy[1] = ifb.iss_rdy;
  assign o_x1[0] = ifa.x1_r;      assign o_x1[1] = ifb.x1_r;

  // Architectural model: one register array and pending array per instance.
  logic [XLEN-1:0] mreg  [2][32];
  bit              mpend [2][32];
  int              nreg  [2] = '{32, 16};
  bit              byp   [2] = '{1'b1, 1'b0};

  int checks = 0;
  int errors = 0;

  // Value landing in register r this cycle: the highest enabled port aimed at it.
  function automatic bit m_wr(int i, int r, output logic [XLEN-1:0] v);
    v = '0;
    if (r == 0 || r >= nreg[i]) return 1'b0;
    for (int p = WRP - 1; p >= 0; p--) begin
      if (d_wr_en[p] && int'(d_wr_idx[p]) == r) begin
        v = d_wr_dat[p];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] m_dat(int i, int k);
    int r = int'(d_rd_idx[k]);
    logic [XLEN-1:0] v;
    if (r == 0 || r >= nreg[i]) return '0;
    if (byp[i] && m_wr(i, r, v)) return v;
    return mreg[i][r];
  endfunction

  function automatic bit m_pend(int i, int k);
    int r = int'(d_rd_idx[k]);
    logic [XLEN-1:0] v;
    if (r == 0 || r >= nreg[i]) return 1'b0;
    if (byp[i] && m_wr(i, r, v)) return 1'b0;
    return mpend[i][r];
  endfunction

  function automatic bit m_rdy(int i);
    int r = int'(d_iss_idx);
    logic [XLEN-1:0] v;
    if (r == 0 || r >= nreg[i]) return 1'b1;
    return !mpend[i][r] || m_wr(i, r, v);
  endfunction

  task automatic idle();
    for (int k = 0; k < RDP; k++) d_rd_idx[k] = '0;
    for (int p = 0; p < WRP; p++) begin
      d_wr_en[p]  = 1'b0;
      d_wr_idx[p] = '0;
      d_wr_dat[p] = '0;
    end
    d_iss_vld = 1'b0;
    d_iss_idx = '0;
    d_flush   = 1'b0;
  endtask

  // Advance one clock with the current inputs and update the model.
  task automatic step();
    logic [XLEN-1:0] nv [2][32];
    bit wh [2][32];
    bit rdy [2];
    int ii;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = m_rdy(i);
      for (int r = 0; r < 32; r++) wh[i][r] = m_wr(i, r, nv[i][r]);
    end
    ii = int'(d_iss_idx);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          mreg[i][r]  = '0;
          mpend[i][r] = 1'b0;
        end
      end else begin
        for (int r = 0; r < 32; r++) begin
          if (wh[i][r]) begin
            mreg[i][r]  = nv[i][r];
            mpend[i][r] = 1'b0;
          end
        end
        if (d_flush) begin
          for (int r = 0; r < 32; r++) mpend[i][r] = 1'b0;
        end else if (d_iss_vld && rdy[i] && ii != 0 && ii < nreg[i]) begin
          mpend[i][ii] = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < RDP; k++) d_rd_idx[k] = IW'(g * RDP + k);
      d_iss_idx = IW'(g * 4 + 1);
      #1;
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < RDP; k++) begin
          checks++;
          if (o_dat[i][k*XLEN +: XLEN] !== '0) begin
            errors++;
            $display("FAIL reset_dat inst%0d idx%0d got %h exp 0", i, g*RDP+k, o_dat[i][k*XLEN +: XLEN]);
          end
          checks++;
          if (o_pend[i][k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_pend inst%0d idx%0d got %b exp 0", i, g*RDP+k, o_pend[i][k]);
          end
        end
        checks++;
        if (o_rdy[i] !== 1'b1) begin
          errors++;
          $display("FAIL reset_rdy inst%0d got %b exp 1", i, o_rdy[i]);
        end
        checks++;
        if (o_x1[i] !== '0) begin
          errors++;
          $display("FAIL reset_x1 inst%0d got %h exp 0", i, o_x1[i]);
        end
      end
      step();
    end
    idle();
    d_wr_en[0] = 1'b1; d_wr_idx[0] = 5'd0; d_wr_dat[0] = 32'hDEADBEEF;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_dat[i][XLEN-1:0] !== '0) begin
        errors++;
        $display("FAIL x0_bypass inst%0d got %h exp 0", i, o_dat[i][XLEN-1:0]);
      end
    end
    step();
    idle();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_dat[i][XLEN-1:0] !== '0) begin
        errors++;
        $display("FAIL x0_read inst%0d got %h exp 0", i, o_dat[i][XLEN-1:0]);
      end
    end
  endtask

  task automatic test_conflict();
    logic [XLEN-1:0] exp_same [2] = '{32'h22222222, 32'h0};
    idle();
    d_wr_en[0] = 1'b1; d_wr_idx[0] = 5'd5; d_wr_dat[0] = 32'h11111111;
    d_wr_en[1] = 1'b1; d_wr_idx[1] = 5'd5; d_wr_dat[1] = 32'h22222222;
    d_rd_idx[2] = 5'd5;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_dat[i][2*XLEN +: XLEN] !== exp_same[i]) begin
        errors++;
        $display("FAIL conflict_same_cycle inst%0d got %h exp %h", i, o_dat[i][2*XLEN +: XLEN], exp_same[i]);
      end
    end
    step();
    idle();
    d_rd_idx[1] = 5'd5;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_dat[i][XLEN +: XLEN] !== 32'h22222222) begin
        errors++;
        $display("FAIL conflict_winner inst%0d got %h exp 22222222", i, o_dat[i][XLEN +: XLEN]);
      end
    end
  endtask

  task automatic test_pending();
    bit exp_wpend [2] = '{1'b0, 1'b1};
    idle();
    d_iss_vld = 1'b1; d_iss_idx = 5'd7;
    step();
    d_rd_idx[0] = 5'd7;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_pend[i][0] !== 1'b1) begin
        errors++;
        $display("FAIL pend_set inst%0d got %b exp 1", i, o_pend[i][0]);
      end
      checks++;
      if (o_rdy[i] !== 1'b0) begin
        errors++;
        $display("FAIL waw_block inst%0d got %b exp 0", i, o_rdy[i]);
      end
    end
    step();
    d_iss_vld = 1'b0;
    d_wr_en[0] = 1'b1; d_wr_idx[0] = 5'd7; d_wr_dat[0] = 32'h5;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL wb_frees_rdy inst%0d got %b exp 1", i, o_rdy[i]);
      end
      checks++;
      if (o_pend[i][0] !== exp_wpend[i]) begin
        errors++;
        $display("FAIL wb_pend_mask inst%0d got %b exp %b", i, o_pend[i][0], exp_wpend[i]);
      end
    end
    step();
    idle();
    d_rd_idx[3] = 5'd7;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_pend[i][3] !== 1'b0 || o_dat[i][3*XLEN +: XLEN] !== 32'h5) begin
        errors++;
        $display("FAIL wb_done inst%0d got pend %b dat %h exp pend 0 dat 5", i, o_pend[i][3], o_dat[i][3*XLEN +: XLEN]);
      end
    end
  endtask

  task automatic test_issue_and_write();
    idle();
    d_iss_vld = 1'b1; d_iss_idx = 5'd9;
    d_wr_en[1] = 1'b1; d_wr_idx[1] = 5'd9; d_wr_dat[1] = 32'hCAFE0009;
    step();
    idle();
    d_rd_idx[1] = 5'd9;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_dat[i][XLEN +: XLEN] !== 32'hCAFE0009) begin
        errors++;
        $display("FAIL set_wins_dat inst%0d got %h exp cafe0009", i, o_dat[i][XLEN +: XLEN]);
      end
      checks++;
      if (o_pend[i][1] !== 1'b1) begin
        errors++;
        $display("FAIL set_wins_pend inst%0d got %b exp 1", i, o_pend[i][1]);
      end
    end
  endtask

  task automatic test_flush();
    logic [IW-1:0] ids [RDP] = '{5'd3, 5'd4, 5'd6, 5'd8};
    bit pre [RDP] = '{1'b1, 1'b1, 1'b1, 1'b0};
    idle();
    for (int n = 0; n < 3; n++) begin
      d_iss_vld = 1'b1; d_iss_idx = ids[n];
      step();
    end
    idle();
    for (int k = 0; k < RDP; k++) d_rd_idx[k] = ids[k];
    #1;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < RDP; k++) begin
        checks++;
        if (o_pend[i][k] !== pre[k]) begin
          errors++;
          $display("FAIL preflush_pend inst%0d x%0d got %b exp %b", i, ids[k], o_pend[i][k], pre[k]);
        end
      end
    d_flush = 1'b1; d_iss_vld = 1'b1; d_iss_idx = 5'd8;
    step();
    idle();
    for (int k = 0; k < RDP; k++) d_rd_idx[k] = ids[k];
    d_iss_idx = 5'd9;
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < RDP; k++) begin
        checks++;
        if (o_pend[i][k] !== 1'b0) begin
          errors++;
          $display("FAIL flush_pend inst%0d x%0d got %b exp 0", i, ids[k], o_pend[i][k]);
        end
      end
      checks++;
      if (o_rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL flush_rdy9 inst%0d got %b exp 1", i, o_rdy[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    idle();
    d_wr_en[0] = 1'b1; d_wr_idx[0] = 5'd20; d_wr_dat[0] = 32'h12345678;
    d_iss_vld = 1'b1; d_iss_idx = 5'd20;
    d_rd_idx[0] = 5'd20;
    #1;
    checks++;
    if (o_dat[1][XLEN-1:0] !== '0 || o_pend[1][0] !== 1'b0 || o_rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL oor_same_cycle got dat %h pend %b rdy %b exp 0 0 1", o_dat[1][XLEN-1:0], o_pend[1][0], o_rdy[1]);
    end
    step();
    idle();
    d_rd_idx[0] = 5'd20; d_rd_idx[1] = 5'd4; d_iss_idx = 5'd20;
    #1;
    checks++;
    if (o_dat[1][XLEN-1:0] !== '0 || o_pend[1][0] !== 1'b0 || o_rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL oor_after got dat %h pend %b rdy %b exp 0 0 1", o_dat[1][XLEN-1:0], o_pend[1][0], o_rdy[1]);
    end
    checks++;
    if (o_dat[1][XLEN +: XLEN] !== '0) begin
      errors++;
      $display("FAIL oor_alias_x4 got %h exp 0", o_dat[1][XLEN +: XLEN]);
    end
    checks++;
    if (o_dat[0][XLEN-1:0] !== 32'h12345678 || o_pend[0][0] !== 1'b1 || o_rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL x20_in_range got dat %h pend %b rdy %b exp 12345678 1 0", o_dat[0][XLEN-1:0], o_pend[0][0], o_rdy[0]);
    end
  endtask

  task automatic test_rst_mid();
    idle();
    d_wr_en[0] = 1'b1; d_wr_idx[0] = 5'd1; d_wr_dat[0] = 32'h1;
    d_rd_idx[0] = 5'd1;
    #1;
    checks++;
    if (o_x1[0] !== '0 || o_dat[0][XLEN-1:0] !== 32'h1) begin
      errors++;
      $display("FAIL x1_no_bypass got x1_r %h rd %h exp 0 1", o_x1[0], o_dat[0][XLEN-1:0]);
    end
    step();
    idle();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_x1[i] !== 32'h1) begin
        errors++;
        $display("FAIL x1_written inst%0d got %h exp 1", i, o_x1[i]);
      end
    end
    rst = 1'b1;
    d_wr_en[0] = 1'b1; d_wr_idx[0] = 5'd1; d_wr_dat[0] = 32'hA;
    d_iss_vld = 1'b1; d_iss_idx = 5'd2;
    step();
    rst = 1'b0;
    idle();
    d_rd_idx[0] = 5'd1; d_rd_idx[1] = 5'd2; d_iss_idx = 5'd2;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_x1[i] !== '0 || o_dat[i][XLEN-1:0] !== '0) begin
        errors++;
        $display("FAIL rst_mid_x1 inst%0d got x1_r %h rd %h exp 0 0", i, o_x1[i], o_dat[i][XLEN-1:0]);
      end
      checks++;
      if (o_pend[i][1] !== 1'b0 || o_rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_iss inst%0d got pend %b rdy %b exp 0 1", i, o_pend[i][1], o_rdy[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] ed;
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < RDP; k++) d_rd_idx[k] = IW'($urandom_range(0, 31));
      for (int p = 0; p < WRP; p++) begin
        d_wr_en[p]  = ($urandom_range(0, 2) != 0);
        d_wr_idx[p] = IW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
        d_wr_dat[p] = $urandom;
      end
      d_iss_vld = ($urandom_range(0, 1) != 0);
      d_iss_idx = IW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      d_flush   = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      #1;
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < RDP; k++) begin
          ed = m_dat(i, k);
          checks++;
          if (o_dat[i][k*XLEN +: XLEN] !== ed) begin
            errors++;
            $display("FAIL rand_dat n%0d inst%0d port%0d idx%0d got %h exp %h", n, i, k, d_rd_idx[k], o_dat[i][k*XLEN +: XLEN], ed);
          end
          checks++;
          if (o_pend[i][k] !== m_pend(i, k)) begin
            errors++;
            $display("FAIL rand_pend n%0d inst%0d port%0d idx%0d got %b exp %b", n, i, k, d_rd_idx[k], o_pend[i][k], m_pend(i, k));
          end
        end
        checks++;
        if (o_rdy[i] !== m_rdy(i)) begin
          errors++;
          $display("FAIL rand_rdy n%0d inst%0d idx%0d got %b exp %b", n, i, d_iss_idx, o_rdy[i], m_rdy(i));
        end
        checks++;
        if (o_x1[i] !== mreg[i][1]) begin
          errors++;
          $display("FAIL rand_x1 n%0d inst%0d got %h exp %h", n, i, o_x1[i], mreg[i][1]);
        end
      end
      step();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_conflict();
    test_pending();
    test_issue_and_write();
    test_flush();
    test_out_of_range();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
